// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the clocked LFSR pseudo-random generator.
// Provides the word FSM encoding, default tap masks and a one-step LFSR function.
package lfsr_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_t;

    // Maximal-length Fibonacci masks (bit i set = state[i] feeds back)
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [62:0] TAPS_63 = 63'h6000_0000_0000_0000;
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

    // Tap mask for a given width; widths without a table entry fall back
    // to x^n + x^(n-1) + 1, which keeps the top bit in the feedback.
    function automatic logic [63:0] default_taps(input int unsigned n);
        logic [63:0] t;
        unique case (n)
            8:       t = 64'(TAPS_8);
            16:      t = 64'(TAPS_16);
            32:      t = 64'(TAPS_32);
            63:      t = 64'(TAPS_63);
            64:      t = TAPS_64;
            default: t = (64'd3 << (n - 2));
        endcase
        return t;
    endfunction

    // One Fibonacci shift of an n-bit register held in the low bits.
    function automatic logic [63:0] lfsr_next(
        input logic [63:0] state,
        input logic [63:0] taps,
        input int unsigned n
    );
        logic [63:0] mask;
        logic        fb;
        mask = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        fb   = ^(state & taps & mask);
        return ((state << 1) | 64'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_entropy_sync.sv
// Two-flop synchroniser bringing the asynchronous noise bit into clk.
// Ports: clk, reset_n (async, active low), din (any domain), dout (synchronised).
module lfsr_entropy_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign dout = sync_q[1];

endmodule

// File: rtl/lfsr_prng.sv
// Clocked Fibonacci LFSR generator: seed load, entropy mixing, lockup recovery,
// valid/ready word output. Ports: clk, reset_n, seed_load, seed, mix_en,
// entropy_in, rnd_valid, rnd_ready, rnd, state_o, lockup_recovered.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned  N            = 63,
    parameter logic [N-1:0] TAPS         = N'(default_taps(N)),
    parameter int unsigned  OUT_W        = 16,
    parameter int unsigned  ADVANCE      = OUT_W,
    parameter logic [N-1:0] SEED_DEFAULT = N'(1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [N-1:0]     seed,
    input  logic             mix_en,
    input  logic             entropy_in,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [OUT_W-1:0] rnd,
    output logic [N-1:0]     state_o,
    output logic             lockup_recovered
);

    localparam int unsigned   CW       = $clog2(ADVANCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ADVANCE - 1);

    fsm_t             fsm_q;
    fsm_t             fsm_d;
    logic [N-1:0]     state_q;
    logic [N-1:0]     state_d;
    logic [N-1:0]     shifted;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [OUT_W-1:0] rnd_q;
    logic [OUT_W-1:0] rnd_d;
    logic             lock_q;
    logic             lock_d;
    logic             ent_s;
    logic             mix_bit;
    logic             fill_last;
    logic             shift_zero;
    logic             seed_zero;

    lfsr_entropy_sync u_ent_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (entropy_in),
        .dout    (ent_s)
    );

    // Entropy enters at bit 0, i.e. it is XORed into the feedback bit.
    assign mix_bit    = mix_en & ent_s;
    assign shifted    = N'(lfsr_next(64'(state_q), 64'(TAPS), N))
                        ^ N'(mix_bit);
    assign shift_zero = (shifted == '0);
    assign seed_zero  = (seed == '0);
    assign fill_last  = (cnt_q == CNT_LAST);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q <= FILL;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM: next state; a seed load restarts word assembly from any state
    always_comb begin
        fsm_d = fsm_q;
        if (seed_load) begin
            fsm_d = FILL;
        end else begin
            unique case (fsm_q)
                FILL:    if (fill_last) fsm_d = HOLD;
                HOLD:    if (rnd_ready) fsm_d = FILL;
                default: fsm_d = FILL;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        rnd_valid = (fsm_q == HOLD);
    end

    // Datapath next values: LFSR, word counter, word register, lockup flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        lock_d  = 1'b0;
        if (seed_load) begin
            cnt_d = '0;
            if (seed_zero) begin
                state_d = SEED_DEFAULT;
                lock_d  = 1'b1;
            end else begin
                state_d = seed;
            end
        end else if (fsm_q == FILL) begin
            // An all-zero state would never leave zero without entropy
            if (shift_zero) begin
                state_d = SEED_DEFAULT;
                lock_d  = 1'b1;
            end else begin
                state_d = shifted;
            end
            if (fill_last) begin
                cnt_d = '0;
                rnd_d = state_d[OUT_W-1:0];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED_DEFAULT;
            cnt_q   <= '0;
            rnd_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            lock_q  <= lock_d;
        end
    end

    assign rnd              = rnd_q;
    assign state_o          = state_q;
    assign lockup_recovered = lock_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: cycle model plus directed scenarios.
// Model works on plain integer arithmetic over the polynomial x^63+x^62+1.
module tb_lfsr_prng;

    localparam int N     = 63;
    localparam int OUT_W = 16;
    localparam int ADV   = 16;
    localparam logic [62:0] TAPS = 63'h6000_0000_0000_0000;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        seed_load  = 1'b0;
    logic [62:0] seed       = '0;
    logic        mix_en     = 1'b0;
    logic        entropy_in = 1'b0;
    logic        rnd_ready  = 1'b0;
    logic        rnd_valid;
    logic [15:0] rnd;
    logic [62:0] state_o;
    logic        lockup_recovered;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lfsr_prng #(
        .N            (N),
        .TAPS         (TAPS),
        .OUT_W        (OUT_W),
        .ADVANCE      (ADV),
        .SEED_DEFAULT (63'h1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .seed_load        (seed_load),
        .seed             (seed),
        .mix_en           (mix_en),
        .entropy_in       (entropy_in),
        .rnd_valid        (rnd_valid),
        .rnd_ready        (rnd_ready),
        .rnd              (rnd),
        .state_o          (state_o),
        .lockup_recovered (lockup_recovered)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Polynomial step: parity of tapped bits (plus entropy) becomes new LSB
    function automatic logic [63:0] soft_step(input logic [63:0] s,
                                              input bit e);
        int fb;
        fb = ($countones(s & 64'(TAPS)) + int'(e)) % 2;
        return (s * 2 + 64'(fb)) % (64'd1 << 63);
    endfunction

    // ---------------- behavioural model ----------------
    logic [63:0] m_st    = 64'd1;
    bit          m_valid = 1'b0;
    int          m_left  = ADV;
    logic [15:0] m_rnd   = '0;
    bit          m_lock  = 1'b0;
    bit          ent_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st    = 64'd1;
            m_valid = 1'b0;
            m_left  = ADV;
            m_rnd   = '0;
            m_lock  = 1'b0;
            ent_q   = {1'b0, 1'b0};
        end else begin
            bit          e;
            logic [63:0] nx;
            e = ent_q.pop_front();
            ent_q.push_back(entropy_in);
            m_lock = 1'b0;
            if (seed_load) begin
                if (seed == '0) begin
                    m_st   = 64'd1;
                    m_lock = 1'b1;
                end else begin
                    m_st = 64'(seed);
                end
                m_valid = 1'b0;
                m_left  = ADV;
            end else if (m_valid) begin
                if (rnd_ready) begin
                    m_valid = 1'b0;
                    m_left  = ADV;
                end
            end else begin
                nx = soft_step(m_st, mix_en & e);
                if (nx == 64'd0) begin
                    nx     = 64'd1;
                    m_lock = 1'b1;
                end
                m_st   = nx;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_rnd   = m_st[15:0];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            chk("cyc_valid", 64'(rnd_valid), 64'(m_valid));
            chk("cyc_rnd", 64'(rnd), 64'(m_rnd));
            chk("cyc_state", 64'(state_o), m_st);
            chk("cyc_lock", 64'(lockup_recovered), 64'(m_lock));
        end
    end

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rnd_valid && n < limit);
        if (!rnd_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_valid: no rnd_valid within %0d cycles", n);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int          lat;
        logic [63:0] sw;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(rnd_valid), 64'd0);
        chk("rst_rnd", 64'(rnd), 64'd0);
        chk("rst_state", 64'(state_o), 64'd1);
        chk("rst_lock", 64'(lockup_recovered), 64'd0);

        // 1: free run from reset, ready always high
        reset_n   = 1'b1;
        rnd_ready = 1'b1;
        chk_en    = 1'b1;
        wait_valid(100, lat);
        chk("t1_first_lat", 64'(lat), 64'd16);
        sw = 64'd1;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) begin
                wait_valid(40, lat);
                chk("t1_word_lat", 64'(lat), 64'd17);
            end
            repeat (ADV) sw = soft_step(sw, 1'b0);
            chk("t1_word", 64'(rnd), 64'(sw[15:0]));
            if (k == 0) begin
                chk("t1_pin_word0", 64'(rnd), 64'h0);
                chk("t1_pin_state0", 64'(state_o), 64'h1_0000);
            end
        end

        // 2: back-pressure holds the word
        @(negedge clk);
        rnd_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("t2_hold_valid", 64'(rnd_valid), 64'd1);
        chk("t2_hold_rnd", 64'(rnd), 64'(sw[15:0]));
        chk("t2_hold_state", 64'(state_o), sw);
        @(negedge clk);
        rnd_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_valid_drop", 64'(rnd_valid), 64'd0);
        wait_valid(40, lat);
        chk("t2_next_lat", 64'(lat + 1), 64'd17);
        repeat (ADV) sw = soft_step(sw, 1'b0);
        chk("t2_word", 64'(rnd), 64'(sw[15:0]));

        // 3: seed load while the counter sits at 7
        repeat (9) @(negedge clk);
        seed_load = 1'b1;
        seed      = 63'h1234_5678_9ABC_DEF0;
        @(posedge clk);
        #1;
        chk("t3_no_valid", 64'(rnd_valid), 64'd0);
        chk("t3_state_seed", 64'(state_o), 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        seed_load = 1'b0;
        wait_valid(40, lat);
        chk("t3_lat", 64'(lat), 64'd16);
        sw = 64'h1234_5678_9ABC_DEF0;
        repeat (ADV) sw = soft_step(sw, 1'b0);
        chk("t3_word", 64'(rnd), 64'(sw[15:0]));
        chk("t3_pin_word", 64'(rnd), 64'h6CB9);
        chk("t3_state", 64'(state_o), sw);

        // 4: zero seed is replaced by the default
        @(negedge clk);
        seed_load = 1'b1;
        seed      = '0;
        @(posedge clk);
        #1;
        chk("t4_state", 64'(state_o), 64'd1);
        chk("t4_lock_hi", 64'(lockup_recovered), 64'd1);
        @(negedge clk);
        seed_load = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_lock_lo", 64'(lockup_recovered), 64'd0);
        chk("t4_state_next", 64'(state_o), 64'd2);

        // 5: entropy drives the next state to zero
        @(negedge clk);
        mix_en     = 1'b1;
        entropy_in = 1'b1;
        repeat (3) @(negedge clk);
        seed_load = 1'b1;
        seed      = 63'h4000_0000_0000_0000;
        @(negedge clk);
        seed_load = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_state", 64'(state_o), 64'd1);
        chk("t5_lock_hi", 64'(lockup_recovered), 64'd1);
        @(negedge clk);
        mix_en     = 1'b0;
        entropy_in = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_lock_lo", 64'(lockup_recovered), 64'd0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rnd_ready  = ($urandom_range(0, 1) == 1);
            mix_en     = ($urandom_range(0, 3) == 0);
            entropy_in = 1'($urandom_range(0, 1));
            seed_load  = ($urandom_range(0, 63) == 0);
            seed       = ($urandom_range(0, 3) == 0) ? 63'd0
                         : 63'({$urandom, $urandom});
        end
        @(negedge clk);
        seed_load  = 1'b0;
        mix_en     = 1'b0;
        entropy_in = 1'b0;
        rnd_ready  = 1'b0;

        // 6: asynchronous reset during HOLD
        wait_valid(60, lat);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", 64'(rnd_valid), 64'd0);
        chk("t6_rnd", 64'(rnd), 64'd0);
        chk("t6_state", 64'(state_o), 64'd1);
        chk("t6_lock", 64'(lockup_recovered), 64'd0);
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        rnd_ready = 1'b1;
        wait_valid(100, lat);
        chk("t6_first_lat", 64'(lat), 64'd16);
        chk("t6_pin_state0", 64'(state_o), 64'h1_0000);
        sw = 64'd1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                wait_valid(40, lat);
                chk("t6_word_lat", 64'(lat), 64'd17);
            end
            repeat (ADV) sw = soft_step(sw, 1'b0);
            chk("t6_word", 64'(rnd), 64'(sw[15:0]));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
